role_kernel_launch_scheduler: RTL and testbench

//  Sequences repeated invocations of the role's HLS kernel (ap_ctrl_hs handshake) once the DDR4 channels are calibrated.

---
 rtl/role_kernel_launch_scheduler.sv | 168 ++++++++++++++++
 tb/tb_role_kernel_launch_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/role_kernel_launch_scheduler.sv
// Launches a batch of ap_ctrl_hs kernel invocations, round-robining each onto a
// calibrated DDR channel and reporting the completed-invocation count.
module role_kernel_launch_scheduler #(
  parameter int N_CH    = 3,
  parameter int IW      = 16,
  parameter int TIMEOUT = 1000000,
  localparam int SW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLK_IN_250,
  input  logic            AXI_RESET_N,
  input  logic [N_CH-1:0] calib_complete,
  input  logic            cfg_start,
  input  logic [IW-1:0]   cfg_iter,
  input  logic [N_CH-1:0] cfg_ch_mask,
  input  logic            cfg_abort,
  output logic            ap_start,
  input  logic            ap_ready,
  input  logic            ap_done,
  output logic [SW-1:0]   ddr_sel,
  output logic [31:0]     ker_count,
  output logic            ker_count_ap_vld,
  output logic            busy,
  output logic            batch_done,
  output logic            err_timeout
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CAL = 3'd1,
    ISSUE    = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_remaining;
  logic [N_CH-1:0] r_mask;
  logic [SW-1:0]   r_rr_ptr;
  logic [SW-1:0]   r_ddr_sel;
  logic            r_ap_start;
  logic [31:0]     r_ker_count;
  logic            r_vld;
  logic            r_batch_done;
  logic            r_err_timeout;
  logic            r_abort_pend;
  logic [TW-1:0]   r_tcnt;

  logic [N_CH-1:0] w_elig;
  logic [SW-1:0]   w_pick;
  logic            w_any;
  logic [TW-1:0]   w_tnext;
  logic            w_complete;

  assign w_elig     = calib_complete & r_mask;
  assign w_tnext    = r_tcnt + 1'b1;
  assign w_complete = ap_done && ((r_state == RUN) || ((r_state == ISSUE) && ap_ready));

  // Nearest eligible channel strictly after r_rr_ptr, wrapping around.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      int unsigned idx;
      idx = (int'(r_rr_ptr) + i) % N_CH;
      if (!w_any && w_elig[idx]) begin
        w_pick = SW'(idx);
        w_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_IN_250 or negedge AXI_RESET_N) begin
    if (!AXI_RESET_N) begin
      r_state       <= IDLE;
      r_remaining   <= '0;
      r_mask        <= '0;
      r_rr_ptr      <= SW'(N_CH - 1);
      r_ddr_sel     <= '0;
      r_ap_start    <= 1'b0;
      r_ker_count   <= '0;
      r_vld         <= 1'b0;
      r_batch_done  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_abort_pend  <= 1'b0;
      r_tcnt        <= '0;
    end else begin
      r_vld        <= 1'b0;
      r_batch_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_remaining   <= cfg_iter;
            r_mask        <= cfg_ch_mask;
            r_ker_count   <= '0;
            r_err_timeout <= 1'b0;
            r_abort_pend  <= 1'b0;
            r_state       <= ((cfg_iter == '0) || (cfg_ch_mask == '0)) ? DONE : WAIT_CAL;
          end
        end
        WAIT_CAL: begin
          if (cfg_abort) begin
            r_state <= DONE;
          end else if (w_any) begin
            r_state    <= ISSUE;
            r_ap_start <= 1'b1;
            r_ddr_sel  <= w_pick;
            r_rr_ptr   <= w_pick;
          end
        end
        ISSUE: begin
          // Once the kernel has taken the start, an abort can only stop re-issue.
          if (ap_ready) begin
            r_ap_start   <= 1'b0;
            r_tcnt       <= '0;
            r_abort_pend <= r_abort_pend | cfg_abort;
            r_state      <= RUN;
          end else if (cfg_abort) begin
            r_ap_start <= 1'b0;
            r_state    <= DONE;
          end
        end
        RUN: begin
          r_tcnt <= w_tnext;
          if (cfg_abort) r_abort_pend <= 1'b1;
          if (!ap_done && (TIMEOUT != 0) && (w_tnext == TMAX)) begin
            r_err_timeout <= 1'b1;
            r_state       <= DONE;
          end
        end
        DONE: begin
          r_batch_done <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Completion handling is shared by RUN and the ready+done case in ISSUE,
      // so it is applied after the case and overrides the state chosen there.
      if (w_complete) begin
        r_ker_count <= r_ker_count + 32'd1;
        r_vld       <= 1'b1;
        r_remaining <= r_remaining - 1'b1;
        if ((r_remaining == IW'(1)) || r_abort_pend || cfg_abort) begin
          r_state <= DONE;
        end else if (w_any) begin
          r_state    <= ISSUE;
          r_ap_start <= 1'b1;
          r_ddr_sel  <= w_pick;
          r_rr_ptr   <= w_pick;
        end else begin
          r_state <= WAIT_CAL;
        end
      end
    end
  end

  assign ap_start         = r_ap_start;
  assign ddr_sel          = r_ddr_sel;
  assign ker_count        = r_ker_count;
  assign ker_count_ap_vld = r_vld;
  assign busy             = (r_state != IDLE);
  assign batch_done       = r_batch_done;
  assign err_timeout      = r_err_timeout;

endmodule

// File: tb/tb_role_kernel_launch_scheduler.sv
// Directed bench for role_kernel_launch_scheduler: table of batch scenarios
// plus hand-written sequences for calibration wait, timeout, abort and reset.
module tb_role_kernel_launch_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  calib_complete;
  logic        cfg_start;
  logic [15:0] cfg_iter;
  logic [2:0]  cfg_ch_mask;
  logic        cfg_abort;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic [1:0]  ddr_sel;
  logic [31:0] ker_count;
  logic        ker_count_ap_vld;
  logic        busy;
  logic        batch_done;
  logic        err_timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  role_kernel_launch_scheduler #(.N_CH(3), .IW(16), .TIMEOUT(100)) dut (
    .CLK_IN_250       (clk),
    .AXI_RESET_N      (rst_n),
    .calib_complete   (calib_complete),
    .cfg_start        (cfg_start),
    .cfg_iter         (cfg_iter),
    .cfg_ch_mask      (cfg_ch_mask),
    .cfg_abort        (cfg_abort),
    .ap_start         (ap_start),
    .ap_ready         (ap_ready),
    .ap_done          (ap_done),
    .ddr_sel          (ddr_sel),
    .ker_count        (ker_count),
    .ker_count_ap_vld (ker_count_ap_vld),
    .busy             (busy),
    .batch_done       (batch_done),
    .err_timeout      (err_timeout)
  );

  typedef struct {
    logic [2:0]  calib;
    logic [2:0]  mask;
    int          iter;
    int          lat;
    logic [15:0] sels;
  } row_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_batch(input logic [2:0] calib, input logic [2:0] mask, input int iter);
    calib_complete = calib;
    cfg_ch_mask    = mask;
    cfg_iter       = 16'(iter);
    cfg_start      = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("count_cleared", ker_count, 32'd0);
  endtask

  task automatic wait_start(output bit ok);
    int j = 0;
    while (!ap_start && j < 300) begin
      tick();
      j++;
    end
    ok = ap_start;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ap_start_wait: got 0 expected 1 within 300 cycles");
    end
  endtask

  task automatic serve(input int n, input int lat, input logic [15:0] sels, input int base);
    bit ok;
    logic [1:0] exp_sel;
    for (int i = 0; i < n; i++) begin
      wait_start(ok);
      if (!ok) return;
      exp_sel = sels[2*i +: 2];
      chk("ddr_sel", {30'd0, ddr_sel}, {30'd0, exp_sel});
      ap_ready = 1'b1;
      if (lat == 0) ap_done = 1'b1;
      tick();
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      if (lat > 0) begin
        chk("ap_start_low_in_run", {31'd0, ap_start}, 32'd0);
        repeat (lat - 1) tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
      end
      chk("ker_count", ker_count, 32'(base + i + 1));
      chk("ap_vld", {31'd0, ker_count_ap_vld}, 32'd1);
    end
  endtask

  task automatic expect_batch_done(input int exp_count);
    int pulses = 0;
    int starts = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (batch_done) pulses++;
      if (ap_start) starts++;
    end
    chk("batch_done_pulses", 32'(pulses), 32'd1);
    chk("no_extra_ap_start", 32'(starts), 32'd0);
    chk("idle_after_batch", {31'd0, busy}, 32'd0);
    chk("final_count", ker_count, 32'(exp_count));
  endtask

  row_t rows [5];

  initial begin
    bit ok;
    int busy_cycles;
    int pulses;
    int starts;

    rows[0] = '{calib: 3'b111, mask: 3'b111, iter: 4, lat: 10, sels: 16'h0024};
    rows[1] = '{calib: 3'b111, mask: 3'b101, iter: 3, lat: 3,  sels: 16'h0022};
    rows[2] = '{calib: 3'b011, mask: 3'b111, iter: 3, lat: 2,  sels: 16'h0004};
    rows[3] = '{calib: 3'b110, mask: 3'b011, iter: 2, lat: 1,  sels: 16'h0005};
    rows[4] = '{calib: 3'b111, mask: 3'b111, iter: 3, lat: 0,  sels: 16'h0012};

    rst_n = 1'b0;
    calib_complete = 3'b000;
    cfg_start = 1'b0;
    cfg_iter = '0;
    cfg_ch_mask = '0;
    cfg_abort = 1'b0;
    ap_ready = 1'b0;
    ap_done = 1'b0;
    #22 rst_n = 1'b1;
    tick();

    chk("rst_ap_start", {31'd0, ap_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ker_count", ker_count, 32'd0);
    chk("rst_ddr_sel", {30'd0, ddr_sel}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_batch_done", {31'd0, batch_done}, 32'd0);

    for (int r = 0; r < 5; r++) begin
      start_batch(rows[r].calib, rows[r].mask, rows[r].iter);
      serve(rows[r].iter, rows[r].lat, rows[r].sels, 0);
      expect_batch_done(rows[r].iter);
    end

    // No channel calibrated: nothing issues until ch2 comes up.
    start_batch(3'b000, 3'b111, 2);
    starts = 0;
    repeat (50) begin
      tick();
      if (ap_start) starts++;
    end
    chk("no_start_uncalibrated", 32'(starts), 32'd0);
    calib_complete = 3'b100;
    serve(2, 4, 16'h000A, 0);
    expect_batch_done(2);

    // Zero iterations: short busy, one batch_done, kernel untouched.
    calib_complete = 3'b111;
    start_batch(3'b111, 3'b111, 0);
    busy_cycles = 1;
    pulses = 0;
    starts = 0;
    for (int k = 0; k < 6; k++) begin
      if (ap_start) starts++;
      tick();
      if (busy) busy_cycles++;
      if (batch_done) pulses++;
    end
    n_cmp++;
    if (busy_cycles < 1 || busy_cycles > 2) begin
      n_fail++;
      $display("FAIL iter0_busy_cycles: got %0d expected 1..2", busy_cycles);
    end
    chk("iter0_batch_done", 32'(pulses), 32'd1);
    chk("iter0_no_start", 32'(starts), 32'd0);
    chk("iter0_count", ker_count, 32'd0);

    // Kernel hangs: timeout after 100 RUN cycles.
    start_batch(3'b111, 3'b111, 1);
    wait_start(ok);
    if (ok) begin
      chk("to_ddr_sel", {30'd0, ddr_sel}, 32'd0);
      ap_ready = 1'b1;
      tick();
      ap_ready = 1'b0;
      repeat (98) tick();
      chk("to_err_not_yet", {31'd0, err_timeout}, 32'd0);
      chk("to_still_busy", {31'd0, busy}, 32'd1);
      for (int k = 0; k < 4 && !err_timeout; k++) tick();
      chk("to_err_set", {31'd0, err_timeout}, 32'd1);
      chk("to_ap_start_low", {31'd0, ap_start}, 32'd0);
      expect_batch_done(0);
      chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);
    end
    start_batch(3'b111, 3'b111, 1);
    chk("to_err_cleared", {31'd0, err_timeout}, 32'd0);
    serve(1, 2, 16'h0001, 0);
    expect_batch_done(1);

    // Abort while invocation 2 of 5 is running.
    start_batch(3'b111, 3'b111, 5);
    serve(1, 3, 16'h0002, 0);
    wait_start(ok);
    if (ok) begin
      chk("ab_ddr_sel", {30'd0, ddr_sel}, 32'd0);
      ap_ready = 1'b1;
      tick();
      ap_ready = 1'b0;
      tick();
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      repeat (4) tick();
      chk("ab_waits_for_done", {31'd0, busy}, 32'd1);
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      chk("ab_count", ker_count, 32'd2);
      expect_batch_done(2);
    end

    // Async reset while ISSUE is holding ap_start.
    start_batch(3'b111, 3'b111, 2);
    wait_start(ok);
    rst_n = 1'b0;
    #1;
    chk("arst_ap_start", {31'd0, ap_start}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("arst_no_batch_done", {31'd0, batch_done}, 32'd0);
    rst_n = 1'b1;
    tick();
    start_batch(3'b111, 3'b111, 2);
    serve(2, 2, 16'h0004, 0);
    expect_batch_done(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
